// File: rtl/bitrev_pkg.sv
// ---------------------------------------------------------------------------
// bitrev_pkg
// Shared definitions for the bit-reversal reorder buffer.
//   bank_state_t : per-bank lifecycle (EMPTY -> FILLING -> FULL -> DRAINING)
//   NUM_BANKS    : number of ping-pong banks (2)
//   MAX_N        : widest supported log2 frame length
//   rev_bits()   : reference N-bit reverse, for testbench models
// ---------------------------------------------------------------------------
package bitrev_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    localparam int NUM_BANKS = 2;
    localparam int MAX_N     = 12;

    // Reverse the low n bits of x. The full MAX_N-bit word is mirrored with
    // constant indices, then shifted down so only the n reversed bits remain.
    function automatic logic [MAX_N-1:0] rev_bits(input logic [MAX_N-1:0] x,
                                                  input int               n);
        logic [MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++) begin
            r[i] = x[MAX_N-1-i];
        end
        return r >> (MAX_N - n);
    endfunction

endpackage

// File: rtl/bitrev_addr.sv
// ---------------------------------------------------------------------------
// bitrev_addr
// Combinational N-bit index reverser with a pass-through select.
// Ports:
//   idx    in  N  linear index
//   bypass in  1  1 = pass idx through unchanged
//   addr   out N  bit-reversed idx, or idx when bypass = 1
// ---------------------------------------------------------------------------
module bitrev_addr #(
    parameter int N = 3
) (
    input  logic [N-1:0] idx,
    input  logic         bypass,
    output logic [N-1:0] addr
);

    logic [N-1:0] rev;

    for (genvar i = 0; i < N; i++) begin : g_rev
        assign rev[i] = idx[N-1-i];
    end

    assign addr = bypass ? idx : rev;

endmodule

// File: rtl/bitrev_reorder_buf.sv
// ---------------------------------------------------------------------------
// bitrev_reorder_buf
// Streaming bit-reversal reorder buffer. Frames of 2^N samples arrive in
// bit-reversed order and leave in natural order. Two ping-pong banks let one
// frame be written while the previous one is read, so both sides sustain one
// sample per cycle.
//
// Parameters:
//   N  : log2 of frame length (1..12)
//   DW : sample width (opaque payload)
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   input sample present
//   in_ready   out  1   buffer can accept the input sample
//   in_data    in   DW  input sample, bit-reversed order within the frame
//   in_last    in   1   producer's end-of-frame marker (checked, not trusted)
//   bypass     in   1   only with BITREV_BYPASS_EN: store frame in arrival order
//   out_valid  out  1   output sample present
//   out_ready  in   1   consumer accepts the output sample
//   out_data   out  DW  output sample, natural order
//   out_last   out  1   high with sample index 2^N-1 of each output frame
//   frame_err  out  1   sticky: in_last disagreed with the write count
//
// Build option:
//   BITREV_BYPASS_EN : adds the bypass port and per-bank bypass flag.
// ---------------------------------------------------------------------------
module bitrev_reorder_buf
    import bitrev_pkg::*;
#(
    parameter int N  = 3,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
`ifdef BITREV_BYPASS_EN
    input  logic          bypass,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          frame_err
);

    localparam int           DEPTH   = 1 << N;
    localparam logic [N-1:0] CNT_MAX = '1;

    // Bank lifecycle state and write/read pointers (control, reset).
    bank_state_t state     [NUM_BANKS];
    bank_state_t state_nxt [NUM_BANKS];
    logic        wbank;
    logic        rbank;
    logic [N-1:0] wcnt;
    logic [N-1:0] rcnt;

    // Sample storage (data, not reset).
    logic [DW-1:0] mem [NUM_BANKS][DEPTH];

    logic                 wr_acc;
    logic                 rd_acc;
    logic                 wlast;
    logic                 rlast;
    logic [NUM_BANKS-1:0] wr_hit;
    logic [NUM_BANKS-1:0] rd_hit;
    logic                 byp_sel;
    logic [N-1:0]         waddr;

    assign wr_acc = in_valid & in_ready;
    assign rd_acc = out_valid & out_ready;
    assign wlast  = (wcnt == CNT_MAX);
    assign rlast  = (rcnt == CNT_MAX);

    // One-hot bank selects for this cycle's accepted write / read.
    assign wr_hit = {NUM_BANKS{wr_acc}} & (NUM_BANKS'(1) << wbank);
    assign rd_hit = {NUM_BANKS{rd_acc}} & (NUM_BANKS'(1) << rbank);

    // -----------------------------------------------------------------------
    // Bank FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state[b] <= EMPTY;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state[b] <= state_nxt[b];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Bank FSM: next state. A bank is only ever written while EMPTY/FILLING
    // and only read while FULL/DRAINING, so a single bank never sees both a
    // write and a read in the same cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            state_nxt[b] = state[b];
            case (state[b])
                EMPTY: begin
                    if (wr_hit[b]) begin
                        state_nxt[b] = wlast ? FULL : FILLING;
                    end
                end
                FILLING: begin
                    if (wr_hit[b] && wlast) begin
                        state_nxt[b] = FULL;
                    end
                end
                FULL: begin
                    if (rd_hit[b]) begin
                        state_nxt[b] = rlast ? EMPTY : DRAINING;
                    end
                end
                DRAINING: begin
                    if (rd_hit[b] && rlast) begin
                        state_nxt[b] = EMPTY;
                    end
                end
                default: state_nxt[b] = EMPTY;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Bank FSM: outputs. Both handshake outputs come purely from registered
    // state and pointers, so there is no in_valid->out_valid or
    // out_ready->in_ready combinational path.
    // -----------------------------------------------------------------------
    always_comb begin
        in_ready  = (state[wbank] == EMPTY) || (state[wbank] == FILLING);
        out_valid = (state[rbank] == FULL)  || (state[rbank] == DRAINING);
        out_last  = out_valid && rlast;
    end

    // Write pointer: the frame boundary comes from wcnt alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt  <= '0;
            wbank <= 1'b0;
        end else if (wr_acc) begin
            wcnt <= wcnt + 1'b1;
            if (wlast) begin
                wbank <= ~wbank;
            end
        end
    end

    // Read pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt  <= '0;
            rbank <= 1'b0;
        end else if (rd_acc) begin
            rcnt <= rcnt + 1'b1;
            if (rlast) begin
                rbank <= ~rbank;
            end
        end
    end

    // Sticky framing error: in_last must coincide with the final write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else if (wr_acc && (in_last != wlast)) begin
            frame_err <= 1'b1;
        end
    end

`ifdef BITREV_BYPASS_EN
    // Bypass is latched per bank on the frame's first write. That first
    // write must already honour it, so it uses the live port value.
    logic [NUM_BANKS-1:0] byp_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_flag <= '0;
        end else if (wr_acc && (state[wbank] == EMPTY)) begin
            byp_flag[wbank] <= bypass;
        end
    end

    assign byp_sel = (state[wbank] == EMPTY) ? bypass : byp_flag[wbank];
`else
    assign byp_sel = 1'b0;
`endif

    bitrev_addr #(
        .N (N)
    ) u_waddr (
        .idx    (wcnt),
        .bypass (byp_sel),
        .addr   (waddr)
    );

    // Storage write: sample k of the frame lands at rev(k).
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wbank][waddr] <= in_data;
        end
    end

    // Natural-order read straight from the flops.
    assign out_data = mem[rbank][rcnt];

endmodule

// File: tb/tb_bitrev_reorder_buf.sv
module tb_bitrev_reorder_buf;
    import bitrev_pkg::*;

    localparam int N    = 3;
    localparam int DW   = 16;
    localparam int FLEN = 1 << N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          bypass = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          frame_err;

    int vectors = 0;
    int errors  = 0;

    // Scoreboard: {last, data} expected in output order.
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] fbuf[FLEN];
    int            in_k = 0;
    logic          byp_frame = 1'b0;

    always #5 clk = ~clk;

    bitrev_reorder_buf #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
`ifdef BITREV_BYPASS_EN
        .bypass    (bypass),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .frame_err (frame_err)
    );

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1, "timeout");
    end

    // One clock cycle: drive inputs, sample handshakes on the falling edge,
    // return just after the next rising edge.
    task automatic cyc(input logic iv, input logic [DW-1:0] id, input logic il,
                       input logic ordy, output logic ia, output logic oa,
                       output logic [DW-1:0] od, output logic ol,
                       output logic ov, output logic ir);
        in_valid  = iv;
        in_data   = id;
        in_last   = il;
        out_ready = ordy;
        @(negedge clk);
        ia = in_valid & in_ready;
        oa = out_valid & out_ready;
        od = out_data;
        ol = out_last;
        ov = out_valid;
        ir = in_ready;
        @(posedge clk);
        #1;
    endtask

    // Record an accepted input; on the frame's last sample queue the
    // natural-order expectation for the whole frame.
    task automatic note_in(input logic [DW-1:0] d);
        if (in_k == 0) byp_frame = bypass;
        fbuf[in_k] = d;
        if (in_k == FLEN-1) begin
            for (int j = 0; j < FLEN; j++) begin
                int src;
                src = byp_frame ? j : int'(rev_bits(12'(j), N));
                exp_q.push_back({(j == FLEN-1), fbuf[src]});
            end
            in_k = 0;
        end else begin
            in_k++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
        vectors++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b, expected 0", out_last); end
        vectors++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b, expected 1", in_ready); end
        exp_q.delete();
        in_k = 0;
    endtask

    task automatic test_basic();
        logic [DW-1:0] order [FLEN] = '{16'd0, 16'd4, 16'd2, 16'd6, 16'd1, 16'd5, 16'd3, 16'd7};
        logic ia, oa, ol, ov, ir;
        logic [DW-1:0] od;
        logic [DW:0] e;
        int sent = 0, nout = 0, acc7 = -1, first_ov = -1;
        for (int c = 0; c < 40 && (sent < FLEN || exp_q.size() > 0); c++) begin
            cyc(sent < FLEN, DW'(sent), sent == FLEN-1, 1'b1, ia, oa, od, ol, ov, ir);
            if (ov && first_ov < 0) first_ov = c;
            if (oa) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL basic_extra: got data=%0h, expected no output", od);
                end else begin
                    e = exp_q.pop_front();
                    if ({ol, od} !== e) begin
                        errors++; $display("FAIL basic_out: got last=%b data=%0h, expected last=%b data=%0h", ol, od, e[DW], e[DW-1:0]);
                    end
                end
                vectors++;
                if (nout < FLEN && od !== order[nout]) begin
                    errors++; $display("FAIL basic_order[%0d]: got %0h, expected %0h", nout, od, order[nout]);
                end
                nout++;
            end
            if (ia) begin
                if (sent == FLEN-1) acc7 = c;
                note_in(DW'(sent));
                sent++;
            end
        end
        vectors++;
        if (first_ov !== acc7 + 1) begin errors++; $display("FAIL basic_latency: out_valid first at cycle %0d, expected %0d", first_ov, acc7 + 1); end
        vectors++;
        if (nout !== FLEN || exp_q.size() != 0) begin errors++; $display("FAIL basic_count: got %0d outputs (%0d pending), expected %0d", nout, exp_q.size(), FLEN); end
    endtask

    task automatic test_back_to_back();
        logic ia, oa, ol, ov, ir;
        logic [DW-1:0] od;
        logic [DW:0] e;
        int sent = 0, nout = 0, first_out = -1, last_out = -1, ir_low = 0;
        for (int c = 0; c < 100 && (sent < 4*FLEN || exp_q.size() > 0); c++) begin
            cyc(sent < 4*FLEN, DW'(16'h100 + sent), (sent % FLEN) == FLEN-1, 1'b1, ia, oa, od, ol, ov, ir);
            if (sent < 4*FLEN && !ir) ir_low++;
            if (oa) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra: got data=%0h, expected no output", od);
                end else begin
                    e = exp_q.pop_front();
                    if ({ol, od} !== e) begin
                        errors++; $display("FAIL b2b_out: got last=%b data=%0h, expected last=%b data=%0h", ol, od, e[DW], e[DW-1:0]);
                    end
                end
                if (first_out < 0) first_out = c;
                last_out = c;
                nout++;
            end
            if (ia) begin
                note_in(DW'(16'h100 + sent));
                sent++;
            end
        end
        vectors++;
        if (ir_low != 0) begin errors++; $display("FAIL b2b_in_ready: in_ready low %0d cycles, expected 0", ir_low); end
        vectors++;
        if (last_out - first_out != 4*FLEN-1) begin errors++; $display("FAIL b2b_bubbles: output span %0d cycles, expected %0d", last_out - first_out + 1, 4*FLEN); end
        vectors++;
        if (nout != 4*FLEN || exp_q.size() != 0) begin errors++; $display("FAIL b2b_count: got %0d outputs (%0d pending), expected %0d", nout, exp_q.size(), 4*FLEN); end
    endtask

    task automatic test_backpressure();
        logic ia, oa, ol, ov, ir;
        logic [DW-1:0] od;
        logic [DW:0] e;
        int sent = 0, nout = 0, acc_at_low = -1, acc_at_19 = -1;
        for (int c = 0; c < 120 && (sent < 3*FLEN || exp_q.size() > 0); c++) begin
            cyc(sent < 3*FLEN, DW'(16'h200 + sent), (sent % FLEN) == FLEN-1, c >= 20, ia, oa, od, ol, ov, ir);
            if (sent < 3*FLEN && !ir && acc_at_low < 0) acc_at_low = sent;
            if (oa) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra: got data=%0h, expected no output", od);
                end else begin
                    e = exp_q.pop_front();
                    if ({ol, od} !== e) begin
                        errors++; $display("FAIL bp_out: got last=%b data=%0h, expected last=%b data=%0h", ol, od, e[DW], e[DW-1:0]);
                    end
                end
                nout++;
            end
            if (ia) begin
                note_in(DW'(16'h200 + sent));
                sent++;
            end
            if (c == 19) acc_at_19 = sent;
        end
        vectors++;
        if (acc_at_low != 2*FLEN) begin errors++; $display("FAIL bp_ready_drop: in_ready fell after %0d accepts, expected %0d", acc_at_low, 2*FLEN); end
        vectors++;
        if (acc_at_19 != 2*FLEN) begin errors++; $display("FAIL bp_stalled_accepts: %0d accepts during stall, expected %0d", acc_at_19, 2*FLEN); end
        vectors++;
        if (nout != 3*FLEN || exp_q.size() != 0) begin errors++; $display("FAIL bp_count: got %0d outputs (%0d pending), expected %0d", nout, exp_q.size(), 3*FLEN); end
    endtask

    task automatic test_frame_err();
        logic ia, oa, ol, ov, ir;
        logic [DW-1:0] od;
        logic [DW:0] e;
        int sent = 0, nout = 0;
        vectors++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_initial: got %b, expected 0", frame_err); end
        for (int c = 0; c < 40 && (sent < FLEN || exp_q.size() > 0); c++) begin
            cyc(sent < FLEN, DW'(16'h300 + sent), sent == 4 || sent == FLEN-1, 1'b1, ia, oa, od, ol, ov, ir);
            if (oa) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL ferr_extra: got data=%0h, expected no output", od);
                end else begin
                    e = exp_q.pop_front();
                    if ({ol, od} !== e) begin
                        errors++; $display("FAIL ferr_out: got last=%b data=%0h, expected last=%b data=%0h", ol, od, e[DW], e[DW-1:0]);
                    end
                end
                nout++;
            end
            if (ia) begin
                note_in(DW'(16'h300 + sent));
                vectors++;
                if (sent == 3 && frame_err !== 1'b0) begin errors++; $display("FAIL ferr_early: got %b after sample 3, expected 0", frame_err); end
                if (sent >= 4 && frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b after sample %0d, expected 1", frame_err, sent); end
                sent++;
            end
        end
        vectors++;
        if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %b, expected 1", frame_err); end
        vectors++;
        if (nout != FLEN || exp_q.size() != 0) begin errors++; $display("FAIL ferr_count: got %0d outputs (%0d pending), expected %0d", nout, exp_q.size(), FLEN); end
    endtask

    task automatic test_reset_midframe();
        logic ia, oa, ol, ov, ir;
        logic [DW-1:0] od;
        logic [DW:0] e;
        int sent = 0, nout = 0;
        // One complete frame held by out_ready = 0, then a partial frame.
        for (int c = 0; c < 30 && sent < FLEN + 3; c++) begin
            cyc(1'b1, DW'(16'h400 + sent), (sent % FLEN) == FLEN-1, 1'b0, ia, oa, od, ol, ov, ir);
            if (ia) sent++;
        end
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pending: out_valid %b before reset, expected 1", out_valid); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b, expected 0", out_valid); end
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b, expected 1", in_ready); end
        vectors++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_frame_err: got %b, expected 0", frame_err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        in_k = 0;
        sent = 0;
        for (int c = 0; c < 40 && (sent < FLEN || exp_q.size() > 0); c++) begin
            cyc(sent < FLEN, DW'(16'h500 + sent), sent == FLEN-1, 1'b1, ia, oa, od, ol, ov, ir);
            if (oa) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rstmid_extra: got data=%0h, expected no output", od);
                end else begin
                    e = exp_q.pop_front();
                    if ({ol, od} !== e) begin
                        errors++; $display("FAIL rstmid_out: got last=%b data=%0h, expected last=%b data=%0h", ol, od, e[DW], e[DW-1:0]);
                    end
                end
                nout++;
            end
            if (ia) begin
                note_in(DW'(16'h500 + sent));
                sent++;
            end
        end
        vectors++;
        if (nout != FLEN || exp_q.size() != 0) begin errors++; $display("FAIL rstmid_count: got %0d outputs (%0d pending), expected %0d", nout, exp_q.size(), FLEN); end
    endtask

`ifdef BITREV_BYPASS_EN
    task automatic test_bypass();
        logic ia, oa, ol, ov, ir;
        logic [DW-1:0] od;
        logic [DW:0] e;
        int sent = 0, nout = 0;
        bypass = 1'b1;
        for (int c = 0; c < 40 && (sent < FLEN || exp_q.size() > 0); c++) begin
            cyc(sent < FLEN, DW'(sent), sent == FLEN-1, 1'b1, ia, oa, od, ol, ov, ir);
            if (oa) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL byp_extra: got data=%0h, expected no output", od);
                end else begin
                    e = exp_q.pop_front();
                    if ({ol, od} !== e) begin
                        errors++; $display("FAIL byp_out: got last=%b data=%0h, expected last=%b data=%0h", ol, od, e[DW], e[DW-1:0]);
                    end
                end
                vectors++;
                if (od !== DW'(nout)) begin errors++; $display("FAIL byp_order[%0d]: got %0h, expected %0h", nout, od, nout); end
                nout++;
            end
            if (ia) begin
                note_in(DW'(sent));
                sent++;
            end
        end
        bypass = 1'b0;
        vectors++;
        if (nout != FLEN || exp_q.size() != 0) begin errors++; $display("FAIL byp_count: got %0d outputs (%0d pending), expected %0d", nout, exp_q.size(), FLEN); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_frame_err();
        test_reset_midframe();
`ifdef BITREV_BYPASS_EN
        test_bypass();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
